// File: rtl/miss_tracker.sv
// Miss/hit classifier for presented targets: opens a difficulty-timed window,
// counts hits (score) and misses, and raises game_over. Optional: FALSE_HIT_PENALTY_EN.
module miss_tracker #(
    parameter int unsigned WIN_EASY = 100000000,
    parameter int unsigned WIN_MED  = 50000000,
    parameter int unsigned WIN_HARD = 25000000,
    parameter int unsigned MAX_MISS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] difficulty,
    input  logic       target_valid,
    input  logic       hit,
    output logic [1:0] miss,
    output logic [7:0] score,
    output logic       busy,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic       game_over
);

    typedef enum logic [1:0] {STOP, IDLE, ARMED, OVER} state_t;

    localparam logic [1:0] MAX_MISS_C = 2'(MAX_MISS);

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [31:0] win_len;
    logic [1:0]  miss_n;
    logic [7:0]  score_n;
    logic        hit_pulse_n, miss_pulse_n, game_over_n;
    logic        count_miss;

    // Difficulty only matters at acceptance: loading the timer is the latch.
    always_comb begin
        case (difficulty)
            2'b00:   win_len = WIN_EASY;
            2'b01:   win_len = WIN_MED;
            default: win_len = WIN_HARD;
        endcase
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        miss_n       = miss;
        score_n      = score;
        hit_pulse_n  = 1'b0;
        miss_pulse_n = 1'b0;
        game_over_n  = game_over;
        count_miss   = 1'b0;

        if (start) begin
            state_n     = IDLE;
            miss_n      = 2'd0;
            score_n     = 8'd0;
            game_over_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
`ifdef FALSE_HIT_PENALTY_EN
                    if (hit) begin
                        count_miss = 1'b1;
                    end else if (target_valid) begin
                        timer_n = win_len - 32'd1;
                        state_n = ARMED;
                    end
`else
                    if (target_valid) begin
                        timer_n = win_len - 32'd1;
                        state_n = ARMED;
                    end
`endif
                end
                ARMED: begin
                    // A hit on the last window cycle beats the timeout.
                    if (hit) begin
                        hit_pulse_n = 1'b1;
                        state_n     = IDLE;
                        if (score != 8'hFF) score_n = score + 8'd1;
                    end else if (timer == 32'd0) begin
                        count_miss = 1'b1;
                        state_n    = IDLE;
                    end else begin
                        timer_n = timer - 32'd1;
                    end
                end
                default: ;
            endcase

            if (count_miss) begin
                miss_pulse_n = 1'b1;
                miss_n       = miss + 2'd1;
                if (miss + 2'd1 == MAX_MISS_C) begin
                    game_over_n = 1'b1;
                    state_n     = OVER;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= STOP;
            timer      <= 32'd0;
            miss       <= 2'd0;
            score      <= 8'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            miss       <= miss_n;
            score      <= score_n;
            hit_pulse  <= hit_pulse_n;
            miss_pulse <= miss_pulse_n;
            game_over  <= game_over_n;
        end
    end

    assign busy = (state == ARMED);

endmodule

// File: tb/tb_miss_tracker.sv
// Scoreboard bench for miss_tracker with short windows (8/6/4 cycles, MAX_MISS=3).
module tb_miss_tracker;

    localparam int W = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] difficulty = 2'b00;
    logic       target_valid = 1'b0;
    logic       hit = 1'b0;
    logic [1:0] miss;
    logic [7:0] score;
    logic       busy, hit_pulse, miss_pulse, game_over;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [1:0]   exp_miss = 2'd0;
    logic [7:0]   exp_score = 8'd0;
    logic         exp_go = 1'b0;

    miss_tracker #(
        .WIN_EASY(8),
        .WIN_MED (6),
        .WIN_HARD(4),
        .MAX_MISS(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .difficulty  (difficulty),
        .target_valid(target_valid),
        .hit         (hit),
        .miss        (miss),
        .score       (score),
        .busy        (busy),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_miss  = 2'd0;
        exp_score = 8'd0;
        exp_go    = 1'b0;
    endtask

    task automatic present(input logic [1:0] d);
        difficulty   = d;
        target_valid = 1'b1;
        tick();
        target_valid = 1'b0;
        difficulty   = 2'(($urandom_range(0, 3)));
    endtask

    // Model of one classified target: kind 1 = hit, 0 = miss.
    task automatic exp_push(input logic kind);
        if (kind) begin
            if (exp_score != 8'hFF) exp_score = exp_score + 8'd1;
        end else begin
            exp_miss = exp_miss + 2'd1;
            if (exp_miss == 2'd3) exp_go = 1'b1;
        end
        exp_q.push_back({kind, exp_miss, exp_score, exp_go});
    endtask

    always @(negedge clk) begin
        if (rst_n && (hit_pulse || miss_pulse)) begin
            logic [W-1:0] e;
            check("pulse_excl", 32'(hit_pulse & miss_pulse), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({hit_pulse, miss_pulse}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_event", 32'({hit_pulse, miss, score, game_over}), 32'(e));
            end
        end
    end

    initial begin
        // Reset state and STOP ignoring targets.
        repeat (2) tick();
        check("reset_outputs", 32'({miss, score, busy, hit_pulse, miss_pulse, game_over}), 32'd0);
        rst_n = 1'b1;
        tick();
        present(2'b00);
        check("stop_ignores_target", 32'(busy), 32'd0);
        pulse_start();
        check("after_start", 32'({miss, score, busy, game_over}), 32'd0);

        // Easy target, hit three cycles after acceptance.
        present(2'b00);
        check("easy_busy", 32'(busy), 32'd1);
        repeat (2) tick();
        hit = 1'b1;
        exp_push(1'b1);
        tick();
        hit = 1'b0;
        check("easy_hit_pulse", 32'(hit_pulse), 32'd1);
        check("easy_busy_drop", 32'(busy), 32'd0);
        check("easy_score", 32'(score), 32'd1);
        check("easy_miss", 32'(miss), 32'd0);
        tick();
        check("hit_pulse_one_cycle", 32'(hit_pulse), 32'd0);

        // Three hard timeouts end the game.
        pulse_start();
        for (int r = 0; r < 3; r++) begin
            present(2'b10);
            check("hard_busy", 32'(busy), 32'd1);
            exp_push(1'b0);
            repeat (3) tick();
            check("miss_not_early", 32'(miss_pulse), 32'd0);
            tick();
            check("miss_on_time", 32'(miss_pulse), 32'd1);
            check("miss_busy_drop", 32'(busy), 32'd0);
            check("miss_count", 32'(miss), 32'(r + 1));
        end
        check("go_with_pulse", 32'(game_over), 32'd1);
        present(2'b00);
        check("over_ignores_target", 32'(busy), 32'd0);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("over_holds", 32'({miss, game_over, hit_pulse, miss_pulse}), 32'({2'd3, 1'b1, 2'b00}));

        // Medium window edges: 6th cycle hits, 7th is too late.
        pulse_start();
        check("restart_clears", 32'({miss, score, game_over}), 32'd0);
        present(2'b01);
        repeat (5) tick();
        hit = 1'b1;
        exp_push(1'b1);
        tick();
        hit = 1'b0;
        check("edge_hit", 32'({hit_pulse, miss_pulse}), 32'b10);
        present(2'b01);
        exp_push(1'b0);
        repeat (6) tick();
        check("late_miss_pulse", 32'(miss_pulse), 32'd1);
        hit = 1'b1;
`ifdef FALSE_HIT_PENALTY_EN
        exp_push(1'b0);
`endif
        tick();
        hit = 1'b0;
`ifdef FALSE_HIT_PENALTY_EN
        check("late_hit_penalised", 32'({hit_pulse, miss_pulse, miss}), 32'({2'b01, 2'd2}));
`else
        check("late_hit_ignored", 32'({hit_pulse, miss_pulse, miss}), 32'({2'b00, 2'd1}));
`endif

        // Hit coincident with timeout on a hard window.
        present(2'b10);
        repeat (3) tick();
        hit = 1'b1;
        exp_push(1'b1);
        tick();
        hit = 1'b0;
        check("tie_hit_pulse", 32'({hit_pulse, miss_pulse}), 32'b10);
        check("tie_score", 32'(score), 32'd2);
        check("tie_miss", 32'(miss), 32'(exp_miss));

        // Asynchronous reset in the middle of a window.
        present(2'b00);
        tick();
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'({miss, score, busy, hit_pulse, miss_pulse, game_over}), 32'd0);
        exp_miss  = 2'd0;
        exp_score = 8'd0;
        exp_go    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        present(2'b00);
        check("post_reset_ignores", 32'(busy), 32'd0);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("stop_ignores_hit", 32'({miss_pulse, miss}), 32'd0);

        // Hit while idle.
        pulse_start();
        hit = 1'b1;
`ifdef FALSE_HIT_PENALTY_EN
        exp_push(1'b0);
`endif
        tick();
        hit = 1'b0;
`ifdef FALSE_HIT_PENALTY_EN
        check("idle_hit", 32'({miss_pulse, miss}), 32'({1'b1, 2'd1}));
`else
        check("idle_hit", 32'({miss_pulse, miss}), 32'd0);
`endif

        // Score saturation.
        pulse_start();
        for (int i = 0; i < 258; i++) begin
            present(2'(($urandom_range(0, 3))));
            repeat ($urandom_range(0, 2)) tick();
            hit = 1'b1;
            exp_push(1'b1);
            tick();
            hit = 1'b0;
        end
        check("score_saturated", 32'(score), 32'd255);

        repeat (3) tick();
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miss_tracker.md
Name: miss_tracker

Overview:
- Produces the 2-bit miss count consumed by the HEX4 miss display, plus a game-over flag.
- Opens a timed response window for each presented target and classifies it as a hit or a miss.
  - Hit: a hit pulse arrives inside the window.
  - Miss: the window expires without a hit.
- Window length is selected by the 2-bit difficulty already used by the difficulty display.
- Sits between target generation / player input logic and the display modules.

Parameters:
- WIN_EASY, 100000000, window length in clk cycles for difficulty 2'b00
- WIN_MED, 50000000, window length for difficulty 2'b01
- WIN_HARD, 25000000, window length for difficulty 2'b10 and 2'b11
- MAX_MISS, 3, miss count that ends the game (1..3)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse, begins a new game
- difficulty  input  2  difficulty level, latched when a target is accepted
- target_valid  input  1  single-cycle pulse, a new target has been presented
- hit  input  1  single-cycle pulse, player hit the current target
- miss  output  2  current miss count, to the miss display
- score  output  8  hit count, saturating at 255
- busy  output  1  high while a window is open
- hit_pulse  output  1  one-cycle strobe, target classified as a hit
- miss_pulse  output  1  one-cycle strobe, target classified as a miss
- game_over  output  1  high once miss reaches MAX_MISS

Behaviour:
- Reset (rst_n low, asynchronous): state STOP.
  - All outputs 0: miss=0, score=0, busy=0, hit_pulse=0, miss_pulse=0, game_over=0.
  - Timer 0.
- States: STOP, IDLE, ARMED, OVER.
- start (any state, highest priority): next cycle miss=0, score=0, game_over=0, state IDLE, no pulses.
- STOP: ignores target_valid and hit until start.
- IDLE, target_valid=1:
  - Latch difficulty.
  - Load timer with the selected window minus 1.
  - Next state ARMED; busy=1 from the next cycle.
- ARMED, each cycle:
  - hit=1: next cycle hit_pulse=1, score+1 (saturate at 255), state IDLE, busy=0.
  - Else if timer==0: next cycle miss_pulse=1, miss+1, state IDLE, busy=0.
  - Else: timer decrements.
  - hit and timer==0 in the same cycle: hit wins.
- Window length is exactly N cycles: hit sampled on the Nth cycle after acceptance still counts; the miss pulse is registered at cycle N+1.
- target_valid in ARMED or OVER: ignored, not queued.
- hit in IDLE, STOP or OVER: ignored, unless the optional feature below is compiled in.
- When miss becomes MAX_MISS:
  - game_over=1 in the same cycle as miss_pulse.
  - State OVER.
  - miss holds at MAX_MISS, never wraps.
- OVER: all inputs except start ignored; game_over and miss hold.
- difficulty changes during ARMED have no effect on the open window.
- Reset mid-window: immediate return to STOP; no pulse is emitted.
- hit_pulse and miss_pulse are never high in the same cycle.
- Timer width: 32 bits.

Optional Feature:
- Macro: FALSE_HIT_PENALTY_EN.
- Defined: hit=1 while in IDLE counts as a miss.
  - Next cycle: miss_pulse=1, miss+1, with the same game_over / OVER rules.
  - State stays IDLE unless MAX_MISS is reached.
- Undefined: hit in IDLE is ignored.

Test Plan (bench overrides WIN_EASY=8, WIN_MED=6, WIN_HARD=4, MAX_MISS=3):
- Reset then start; target_valid with difficulty=2'b00; hit 3 cycles later -> hit_pulse one cycle, score=1, miss=0, busy falls with hit_pulse.
- start; target_valid with difficulty=2'b10, no hit -> miss_pulse exactly 5 cycles after target_valid, miss=1; repeat twice -> miss=3 with game_over=1 in the same cycle; a further target_valid leaves busy=0.
- Window edge, difficulty=2'b01: hit on the 6th cycle after acceptance -> hit_pulse, not miss_pulse; hit on the 7th -> miss_pulse, and that hit is ignored.
- Same-cycle hit and timeout -> hit_pulse only, score increments, miss unchanged.
- rst_n low mid-window -> all outputs 0 asynchronously; after release, target_valid ignored until start.
- FALSE_HIT_PENALTY_EN defined: hit in IDLE -> miss_pulse next cycle, miss=1. Undefined: same stimulus -> no pulse, miss=0.
